// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock through a registered carry
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / CHUNK;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [CW-1:0] k;
    logic [WIDTH-1:0] a_r, b_r, sum_n;
    logic c_r;
    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0] t;
    logic acc, last, c_msb;
    assign in_ready = state == IDLE | (state == DONE & out_ready);
    assign out_valid = state == DONE;
    assign acc = in_valid & in_ready;
    assign last = k == CW'(N - 1);
    assign ca = a_r[CHUNK*k +: CHUNK];
    assign cb = b_r[CHUNK*k +: CHUNK];
    assign t = {1'b0, ca} + {1'b0, cb} + (CHUNK + 1)'(c_r);
    // carry into the MSB recovered from the MSB's own sum bit
    assign c_msb = t[CHUNK-1] ^ ca[CHUNK-1] ^ cb[CHUNK-1];
    always_comb begin
        sum_n = sum;
        sum_n[CHUNK*k +: CHUNK] = t[CHUNK-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            a_r <= '0;
            b_r <= '0;
            c_r <= 1'b0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            zero <= 1'b0;
        end else if (acc) begin
            state <= RUN;
            k <= '0;
            a_r <= a;
            b_r <= sub ? ~b : b;
            c_r <= sub ? ~cin : cin;
            sum <= '0;
        end else if (state == RUN) begin
            sum <= sum_n;
            c_r <= t[CHUNK];
            k <= k + 1'b1;
            if (last) begin
                cout <= t[CHUNK];
                ovf <= c_msb ^ t[CHUNK];
                zero <= sum_n == '0;
                state <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: randomized and directed checks of chunked_serial_adder against an arithmetic model
module tb_chunked_serial_adder;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    logic iv0, ir0, cin0, sub0, ov0, or0, co0, ovf0, z0;
    logic [7:0] a0, b0, s0;
    logic iv1, ir1, cin1, sub1, ov1, or1, co1, ovf1, z1;
    logic [7:0] a1, b1, s1;
    logic iv2, ir2, cin2, sub2, ov2, or2, co2, ovf2, z2;
    logic [31:0] a2, b2, s2;

    chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
        .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(ovf0), .zero(z0));
    chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(ovf1), .zero(z1));
    chunked_serial_adder #(.WIDTH(32), .CHUNK(4)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(ovf2), .zero(z2));

    // returns {zero, ovf, cout, sum} for a w-bit add/sub
    function automatic logic [34:0] model(int w, logic [31:0] x, logic [31:0] y, logic c, logic s);
        logic [63:0] m, ey, full;
        logic [31:0] r;
        logic ec, o;
        m = (64'd1 << w) - 64'd1;
        ey = s ? (~{32'd0, y}) & m : {32'd0, y};
        ec = s ? ~c : c;
        full = {32'd0, x} + ey + {63'd0, ec};
        r = full[31:0] & m[31:0];
        o = (x[w-1] == ey[w-1]) && (r[w-1] != x[w-1]);
        return {r == 32'd0, o, full[w], r};
    endfunction

    task automatic op0(input logic [7:0] aa, input logic [7:0] bb, input logic c, input logic s, output int lat);
        for (int i = 0; i < 20 && !ir0; i++) @(negedge clk);
        a0 = aa; b0 = bb; cin0 = c; sub0 = s; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        lat = 1;
        while (!ov0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release0();
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({ir0, ov0, s0, co0, ovf0, z0} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL reset_d0 got ir=%b ov=%b sum=%h c=%b v=%b z=%b want 1 0 00 0 0 0", ir0, ov0, s0, co0, ovf0, z0);
        end
        checks++;
        if ({ir1, ov1, s1, ir2, ov2, s2} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_d1d2 got ir1=%b ov1=%b s1=%h ir2=%b ov2=%b s2=%h", ir1, ov1, s1, ir2, ov2, s2);
        end
    endtask

    task automatic test_reset_in_run();
        logic seen;
        a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({ir0, ov0, s0} !== {1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_in_run got ir=%b ov=%b sum=%h want 1 0 00", ir0, ov0, s0);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= ov0;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_result got out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta[5] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10};
        logic [7:0] tb[5] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h0F};
        logic tc[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic ts[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [10:0] te[5] = '{{8'h00, 3'b101}, {8'h80, 3'b010}, {8'hFE, 3'b000}, {8'h7F, 3'b110}, {8'h00, 3'b101}};
        int lat;
        for (int i = 0; i < 5; i++) begin
            op0(ta[i], tb[i], tc[i], ts[i], lat);
            checks++;
            if (lat !== 5) begin
                failures++;
                $display("FAIL latency_v%0d got %0d want 5", i, lat);
            end
            checks++;
            if ({s0, co0, ovf0, z0} !== te[i]) begin
                failures++;
                $display("FAIL directed_v%0d got sum=%h c=%b v=%b z=%b want %h", i, s0, co0, ovf0, z0, te[i]);
            end
            release0();
        end
    endtask

    task automatic test_backpressure();
        logic [34:0] e;
        int lat;
        e = model(8, 32'h3C, 32'h5A, 1'b0, 1'b0);
        op0(8'h3C, 8'h5A, 1'b0, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); iv0 = 1'($urandom);
            checks++;
            if ({ov0, ir0, z0, ovf0, co0, s0} !== {1'b1, 1'b0, e[34:32], e[7:0]}) begin
                failures++;
                $display("FAIL backpressure_c%0d got ov=%b ir=%b z=%b v=%b c=%b sum=%h want 1 0 %b %h", i, ov0, ir0, z0, ovf0, co0, s0, e[34:32], e[7:0]);
            end
            @(negedge clk);
        end
        iv0 = 1'b0;
        release0();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa[3], pb[3];
        logic pc[3], ps[3];
        logic [7:0] got[$];
        int at[$];
        int idx;
        logic took;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 8'($urandom); pb[i] = 8'($urandom); pc[i] = 1'($urandom); ps[i] = 1'($urandom);
        end
        idx = 0;
        a0 = pa[0]; b0 = pb[0]; cin0 = pc[0]; sub0 = ps[0]; iv0 = 1'b1; or0 = 1'b1;
        for (int c = 0; c < 25; c++) begin
            took = iv0 & ir0;
            if (ov0) begin
                got.push_back(s0);
                at.push_back(c);
            end
            @(negedge clk);
            if (took) begin
                idx++;
                if (idx < 3) begin
                    a0 = pa[idx]; b0 = pb[idx]; cin0 = pc[idx]; sub0 = ps[idx];
                end else iv0 = 1'b0;
            end
        end
        or0 = 1'b0;
        checks++;
        if (got.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count got %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            logic [34:0] e;
            e = model(8, {24'd0, pa[i]}, {24'd0, pb[i]}, pc[i], ps[i]);
            checks++;
            if (got[i] !== e[7:0] || at[i] !== 5 * (i + 1)) begin
                failures++;
                $display("FAIL b2b_r%0d got sum=%h at=%0d want %h at=%0d", i, got[i], at[i], e[7:0], 5 * (i + 1));
            end
        end
    endtask

    task automatic test_degenerate();
        int lat;
        a1 = 8'hC8; b1 = 8'h64; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 2 || {s1, co1, ovf1, z1} !== {8'h2C, 3'b100}) begin
            failures++;
            $display("FAIL n1_add got lat=%0d sum=%h c=%b v=%b z=%b want lat=2 2c 1 0 0", lat, s1, co1, ovf1, z1);
        end
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
    endtask

    task automatic test_random32();
        int bad = 0;
        int lat;
        logic [34:0] e;
        or2 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            a2 = $urandom; b2 = $urandom; cin2 = 1'($urandom); sub2 = 1'($urandom);
            if (i % 10 == 0) b2 = a2;
            e = model(32, a2, b2, cin2, sub2);
            iv2 = 1'b1;
            @(negedge clk);
            iv2 = 1'b0;
            lat = 1;
            while (!ov2 && lat < 30) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat !== 9 || {z2, ovf2, co2, s2} !== e) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand32_v%0d got lat=%0d z=%b v=%b c=%b sum=%h want lat=9 %b %h", i, lat, z2, ovf2, co2, s2, e[34:32], e[31:0]);
            end
            @(negedge clk);
        end
        or2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {iv0, cin0, sub0, or0, a0, b0} = '0;
        {iv1, cin1, sub1, or1, a1, b1} = '0;
        {iv2, cin2, sub2, or2, a2, b2} = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset_in_run();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_degenerate();
        test_random32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
